// File: rtl/shift_pkg.sv
// Shared constants, FSM encoding and helpers for the iterative shift/rotate unit.
package shift_pkg;

    localparam logic [2:0] MODE_LSL = 3'b000;
    localparam logic [2:0] MODE_LSR = 3'b001;
    localparam logic [2:0] MODE_ASR = 3'b010;
    localparam logic [2:0] MODE_ROR = 3'b011;
    localparam logic [2:0] MODE_ROL = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    // Ceiling log2, used to size the shift-count field.
    function automatic int unsigned clogb2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (((v - 1) >> i) != 0) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

    // Modes 101..111 are undefined and pass data through unchanged.
    function automatic logic mode_is_valid(input logic [2:0] m);
        return (m <= MODE_ROL);
    endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response channel between ALU control and the shift sequencer.
interface shift_sequencer_if import shift_pkg::*; #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = clogb2(WIDTH)
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_data;
    logic [CNT_W-1:0] req_count;
    logic [2:0]       req_mode;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_negative;
    logic             rsp_zero;
    logic             rsp_carry;
    logic             busy;

    modport master (
        output req_valid, req_data, req_count, req_mode, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_negative, rsp_zero, rsp_carry, busy
    );

    modport slave (
        input  req_valid, req_data, req_count, req_mode, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_negative, rsp_zero, rsp_carry, busy
    );
endinterface

// File: rtl/shift_step.sv
// One single-bit shift or rotate step; unknown modes hold the word.
module shift_step import shift_pkg::*; #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] w,
    input  logic [2:0]       mode,
    output logic [WIDTH-1:0] w_next,
    output logic             out_bit
);
    // Step table: new word and the bit that falls off the end.
    always_comb begin
        w_next  = w;
        out_bit = 1'b0;
        case (mode)
            MODE_LSL: begin w_next = {w[WIDTH-2:0], 1'b0};      out_bit = w[WIDTH-1]; end
            MODE_LSR: begin w_next = {1'b0, w[WIDTH-1:1]};      out_bit = w[0];       end
            MODE_ASR: begin w_next = {w[WIDTH-1], w[WIDTH-1:1]}; out_bit = w[0];      end
            MODE_ROR: begin w_next = {w[0], w[WIDTH-1:1]};      out_bit = w[0];       end
            MODE_ROL: begin w_next = {w[WIDTH-2:0], w[WIDTH-1]}; out_bit = w[WIDTH-1]; end
            default:  begin w_next = w;                          out_bit = 1'b0;      end
        endcase
    end
endmodule

// File: rtl/shift_sequencer.sv
// Iterative shift/rotate unit: one bit per clock behind valid/ready channels.
module shift_sequencer import shift_pkg::*; #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = clogb2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    shift_sequencer_if.slave bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [2:0]       mode_q, mode_d;
    logic             carry_q, carry_d;

    logic [WIDTH-1:0] step_in, step_out;
    logic [2:0]       step_mode;
    logic             step_bit;
    logic             rsp_valid;

    // In IDLE the step unit sees the incoming operand so the first shift
    // happens on the accepting edge; afterwards it iterates the working word.
    always_comb begin
        step_in   = work_q;
        step_mode = mode_q;
        if (state_q == ST_IDLE) begin
            step_in   = bus.req_data;
            step_mode = bus.req_mode;
        end
    end

    shift_step #(.WIDTH(WIDTH)) u_step (
        .w       (step_in),
        .mode    (step_mode),
        .w_next  (step_out),
        .out_bit (step_bit)
    );

    // Next-state, datapath and count update.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        remain_d = remain_q;
        mode_d   = mode_q;
        carry_d  = carry_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    mode_d = bus.req_mode;
                    if (bus.req_count == '0 || !mode_is_valid(bus.req_mode)) begin
                        work_d   = bus.req_data;
                        carry_d  = 1'b0;
                        remain_d = '0;
                        state_d  = ST_RESP;
                    end else begin
                        work_d   = step_out;
                        carry_d  = step_bit;
                        remain_d = bus.req_count - CNT_W'(1);
                        state_d  = (bus.req_count == CNT_W'(1)) ? ST_RESP : ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                work_d   = step_out;
                carry_d  = step_bit;
                remain_d = remain_q - CNT_W'(1);
                if (remain_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            remain_q <= '0;
            mode_q   <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            remain_q <= remain_d;
            mode_q   <= mode_d;
            carry_q  <= carry_d;
        end
    end

    // Outputs decode straight from flops; response fields are zero unless valid.
    assign rsp_valid        = (state_q == ST_RESP);
    assign bus.rsp_valid    = rsp_valid;
    assign bus.req_ready    = (state_q == ST_IDLE);
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.rsp_data     = rsp_valid ? work_q : '0;
    assign bus.rsp_negative = rsp_valid & work_q[WIDTH-1];
    assign bus.rsp_zero     = rsp_valid & (work_q == '0);
    assign bus.rsp_carry    = rsp_valid & carry_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer against a behavioural shift model.
module tb_shift_sequencer;
    localparam int unsigned W  = 16;
    localparam int unsigned CW = 4;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    shift_sequencer_if #(.WIDTH(W), .CNT_W(CW)) bif ();

    shift_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: apply count single-bit operations using plain arithmetic.
    function automatic void model(input logic [15:0] d, input logic [3:0] c, input logic [2:0] m,
                                  output logic [15:0] r, output logic cy);
        int n;
        n  = (m > 3'd4) ? 0 : int'(c);
        r  = d;
        cy = 1'b0;
        for (int i = 0; i < n; i++) begin
            case (m)
                3'd0: begin cy = r[15]; r = 16'(r << 1); end
                3'd1: begin cy = r[0];  r = r >> 1; end
                3'd2: begin cy = r[0];  r = 16'($signed(r) >>> 1); end
                3'd3: begin cy = r[0];  r = 16'((r >> 1) | (r << 15)); end
                default: begin cy = r[15]; r = 16'((r << 1) | (r >> 15)); end
            endcase
        end
    endfunction

    function automatic int exp_lat(input logic [3:0] c, input logic [2:0] m);
        return (m > 3'd4 || c == 4'd0) ? 1 : int'(c);
    endfunction

    // Issue one request, wait for the response, check it, then hand it off.
    task automatic do_op(input string nm, input logic [15:0] d, input logic [3:0] c, input logic [2:0] m);
        logic [15:0] er;
        logic        ec;
        int          lat;
        int          el;
        model(d, c, m, er, ec);
        el = exp_lat(c, m);
        bif.req_data  = d;
        bif.req_count = c;
        bif.req_mode  = m;
        bif.req_valid = 1'b1;
        bif.rsp_ready = 1'b0;
        total++;
        if (bif.req_ready !== 1'b1) begin
            bad++; $display("FAIL %s req_ready_idle got=%b want=1", nm, bif.req_ready);
        end
        @(posedge clk); #1;
        bif.req_valid = 1'b0;
        bif.req_data  = 16'($urandom);
        bif.req_count = 4'($urandom);
        bif.req_mode  = 3'($urandom);
        lat = 1;
        while (bif.rsp_valid !== 1'b1 && lat < 40) begin
            total++;
            if (bif.busy !== 1'b1 || bif.req_ready !== 1'b0) begin
                bad++; $display("FAIL %s busy_shift busy=%b ready=%b want 1/0", nm, bif.busy, bif.req_ready);
            end
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (lat !== el) begin
            bad++; $display("FAIL %s latency got=%0d want=%0d", nm, lat, el);
        end
        total++;
        if (bif.rsp_data !== er || bif.rsp_carry !== ec) begin
            bad++; $display("FAIL %s result got=%h/c%b want=%h/c%b", nm, bif.rsp_data, bif.rsp_carry, er, ec);
        end
        total++;
        if (bif.rsp_negative !== er[15] || bif.rsp_zero !== (er == 16'h0) || bif.busy !== 1'b1) begin
            bad++; $display("FAIL %s flags got n%b z%b b%b want n%b z%b b1", nm,
                            bif.rsp_negative, bif.rsp_zero, bif.busy, er[15], (er == 16'h0));
        end
        bif.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bif.rsp_ready = 1'b0;
        total++;
        if (bif.rsp_valid !== 1'b0 || bif.req_ready !== 1'b1 || bif.rsp_data !== 16'h0 || bif.busy !== 1'b0) begin
            bad++; $display("FAIL %s after_handshake v%b r%b d%h b%b want v0 r1 d0000 b0", nm,
                            bif.rsp_valid, bif.req_ready, bif.rsp_data, bif.busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bif.req_valid = 1'b0; bif.req_data = '0; bif.req_count = '0; bif.req_mode = '0; bif.rsp_ready = 1'b0;
        #2;
        total++;
        if (bif.rsp_valid !== 1'b0 || bif.rsp_data !== 16'h0 || bif.rsp_negative !== 1'b0 ||
            bif.rsp_zero !== 1'b0 || bif.rsp_carry !== 1'b0 || bif.busy !== 1'b0 || bif.req_ready !== 1'b1) begin
            bad++; $display("FAIL reset_state v%b d%h n%b z%b c%b b%b r%b want all 0, ready 1",
                            bif.rsp_valid, bif.rsp_data, bif.rsp_negative, bif.rsp_zero,
                            bif.rsp_carry, bif.busy, bif.req_ready);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        do_op("lsl_8001_1", 16'h8001, 4'd1, 3'b000);
        do_op("asr_8000_15", 16'h8000, 4'd15, 3'b010);
        do_op("lsr_0001_1", 16'h0001, 4'd1, 3'b001);
        do_op("rol_8000_1", 16'h8000, 4'd1, 3'b100);
        do_op("ror_0001_4", 16'h0001, 4'd4, 3'b011);
    endtask

    task automatic test_passthru();
        do_op("count0_lsl", 16'h1234, 4'd0, 3'b000);
        do_op("mode111", 16'hA5A5, 4'd5, 3'b111);
        do_op("mode101", 16'h0000, 4'd9, 3'b101);
    endtask

    task automatic test_backpressure();
        logic [15:0] er;
        logic        ec;
        int          lat;
        bif.req_data = 16'h00FF; bif.req_count = 4'd3; bif.req_mode = 3'b000;
        bif.req_valid = 1'b1; bif.rsp_ready = 1'b0;
        @(posedge clk); #1;
        bif.req_valid = 1'b0;
        lat = 1;
        while (bif.rsp_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        total++;
        if (lat !== 3) begin bad++; $display("FAIL bp_latency got=%0d want=3", lat); end
        model(16'h00FF, 4'd3, 3'b000, er, ec);
        bif.req_data = 16'h1111; bif.req_count = 4'd2; bif.req_mode = 3'b001; bif.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (bif.rsp_valid !== 1'b1 || bif.rsp_data !== er || bif.rsp_carry !== ec || bif.req_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold cyc%0d v%b d%h c%b r%b want v1 d%h c%b r0", i,
                                bif.rsp_valid, bif.rsp_data, bif.rsp_carry, bif.req_ready, er, ec);
            end
        end
        bif.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bif.rsp_ready = 1'b0;
        total++;
        if (bif.req_ready !== 1'b1 || bif.rsp_valid !== 1'b0 || bif.busy !== 1'b0) begin
            bad++; $display("FAIL bp_release r%b v%b b%b want r1 v0 b0", bif.req_ready, bif.rsp_valid, bif.busy);
        end
        @(posedge clk); #1;
        bif.req_valid = 1'b0;
        lat = 1;
        while (bif.rsp_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        model(16'h1111, 4'd2, 3'b001, er, ec);
        total++;
        if (lat !== 2 || bif.rsp_data !== er || bif.rsp_carry !== ec) begin
            bad++; $display("FAIL bp_next lat=%0d d%h c%b want lat=2 d%h c%b", lat, bif.rsp_data, bif.rsp_carry, er, ec);
        end
        bif.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bif.rsp_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        int seen;
        bif.req_data = 16'hBEEF; bif.req_count = 4'd10; bif.req_mode = 3'b011; bif.req_valid = 1'b1;
        @(posedge clk); #1;
        bif.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (bif.rsp_valid !== 1'b0 || bif.busy !== 1'b0 || bif.req_ready !== 1'b1 || bif.rsp_data !== 16'h0) begin
            bad++; $display("FAIL async_reset v%b b%b r%b d%h want v0 b0 r1 d0000",
                            bif.rsp_valid, bif.busy, bif.req_ready, bif.rsp_data);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        bif.rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bif.rsp_valid === 1'b1 || bif.busy === 1'b1) seen++;
        end
        bif.rsp_ready = 1'b0;
        total++;
        if (seen != 0) begin bad++; $display("FAIL async_no_rsp got=%0d active cycles want=0", seen); end
        do_op("post_reset", 16'hC003, 4'd2, 3'b011);
    endtask

    task automatic test_random();
        for (int k = 0; k < 30; k++) begin
            do_op("random", 16'($urandom), 4'($urandom_range(15, 0)), 3'($urandom_range(7, 0)));
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        logic [15:0] er;
        logic [2:0]  m;
        logic        ec;
        int          last;
        int          hits;
        d = 16'($urandom);
        m = 3'($urandom_range(4, 0));
        model(d, 4'd3, m, er, ec);
        bif.req_data = d; bif.req_count = 4'd3; bif.req_mode = m;
        bif.req_valid = 1'b1; bif.rsp_ready = 1'b1;
        last = -1;
        hits = 0;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            @(posedge clk); #1;
            if (bif.rsp_valid === 1'b1) begin
                hits++;
                total++;
                if ((last < 0 && cyc != 3) || (last >= 0 && cyc - last != 4) ||
                    bif.rsp_data !== er || bif.rsp_carry !== ec) begin
                    bad++; $display("FAIL b2b cyc=%0d prev=%0d d%h c%b want gap 4 d%h c%b",
                                    cyc, last, bif.rsp_data, bif.rsp_carry, er, ec);
                end
                last = cyc;
            end
        end
        total++;
        if (hits != 6) begin bad++; $display("FAIL b2b_count got=%0d want=6", hits); end
        bif.req_valid = 1'b0;
        while (bif.busy === 1'b1 && hits < 50) begin @(posedge clk); #1; hits++; end
        bif.rsp_ready = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_directed();
        test_passthru();
        test_backpressure();
        test_async_reset();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
